cpu_run_ctrl: RTL

Run-control sequencer for the MIPS core's clock-enable. It replaces free-running divided-clock toggling with a prescaled, one-cycle `cpu_en` strobe gated by a run/step/halt state machine. It also provides a PC breakpoint and a runtime-loadable divide ratio. It sits between the board inputs (run/step/stop controls), the core's halt detect and PC, and every register in the core that advances on `cpu_en`.

---
 rtl/cpu_run_ctrl.sv | 77 +++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step/halt sequencer producing a prescaled one-cycle cpu_en strobe,
// with PC breakpoint, runtime divide ratio and saturating tick counter.
module cpu_run_ctrl #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 2500,
  parameter int PC_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             stop_req,
  input  logic             halt_in,
  input  logic             div_wr,
  input  logic [DIV_W-1:0] div_val,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic             bp_hit,
  output logic [31:0]      tick_cnt
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STEP = 2'b10, HALTED = 2'b11} state_t;
  state_t           r_state;
  logic             r_cpu_en;
  logic             r_bp_hit;
  logic             r_bp_skip;
  logic [31:0]      r_tick_cnt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_presc;
  logic             w_active;
  logic             w_due;
  logic             w_bp;
  logic             w_adv;
  assign w_active = r_state == RUN || r_state == STEP;
  assign w_due    = w_active && r_presc == r_div;
  assign w_bp     = bp_en && !r_bp_skip && pc == bp_addr;
  // presc only keeps counting while staying active with no tick, stop, halt or reload
  assign w_adv    = w_active && !w_due && !halt_in && !stop_req && !div_wr;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cpu_en   <= 1'b0;
      r_bp_hit   <= 1'b0;
      r_bp_skip  <= 1'b0;
      r_tick_cnt <= '0;
      r_div      <= DIV_W'(DEFAULT_DIV);
      r_presc    <= '0;
    end else begin
      r_cpu_en <= 1'b0;
      r_presc  <= w_adv ? r_presc + DIV_W'(1) : '0;
      if (div_wr) r_div <= div_val;
      if (r_state == IDLE && (run_req || step_req)) begin
        r_state   <= run_req ? RUN : STEP;
        r_bp_hit  <= 1'b0;
        r_bp_skip <= 1'b1;
      end else if (w_active) begin
        if (halt_in) r_state <= HALTED;
        else if (stop_req) r_state <= IDLE;
        else if (w_due && w_bp) begin
          r_state  <= IDLE;
          r_bp_hit <= 1'b1;
        end else if (w_due) begin
          r_cpu_en  <= 1'b1;
          r_bp_skip <= 1'b0;
          if (~&r_tick_cnt) r_tick_cnt <= r_tick_cnt + 32'd1;
          if (r_state == STEP) r_state <= IDLE;
        end
      end
    end
  end
  assign cpu_en   = r_cpu_en;
  assign state    = r_state;
  assign bp_hit   = r_bp_hit;
  assign tick_cnt = r_tick_cnt;
endmodule
